// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: arms, triggers on detector strobe, gates N samples to DMA, IRQs and holds off.
// Optional WAIT_ACK timeout and timeout_count_o port are built when FRAME_CTRL_TIMEOUT_EN is defined.
module frame_capture_ctrl #(
  parameter int unsigned CFO_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned HOLDOFF   = 64
`ifdef FRAME_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 2**20
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 sample_valid_i,
  input  logic                 det_strobe_i,
  input  logic [CFO_WIDTH-1:0] det_cfo_i,
  input  logic [LEN_WIDTH-1:0] frame_len_i,
  input  logic                 cpu_ack_i,
  output logic                 capture_en_o,
  output logic                 capture_start_o,
  output logic                 capture_done_o,
  output logic                 irq_o,
  output logic [CFO_WIDTH-1:0] cfo_o,
  output logic [2:0]           state_o,
  output logic [31:0]          frame_count_o,
`ifdef FRAME_CTRL_TIMEOUT_EN
  output logic [15:0]          timeout_count_o,
`endif
  output logic [15:0]          overrun_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_HOLDOFF  = 3'd4
  } state_e;

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam state_e POST_ACK = (HOLDOFF == 0) ? ST_ARMED : ST_HOLDOFF;

`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [TO_W-1:0] to_q, to_d;
  logic [15:0]     tocnt_q, tocnt_d;
`endif

  state_e               state_q, state_d;
  logic [CFO_WIDTH-1:0] cfo_q, cfo_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic [31:0]          frames_q, frames_d;
  logic [15:0]          ovr_q, ovr_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cfo_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      frames_q <= '0;
      ovr_q    <= '0;
`ifdef FRAME_CTRL_TIMEOUT_EN
      to_q     <= '0;
      tocnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cfo_q    <= cfo_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      start_q  <= start_d;
      done_q   <= done_d;
      frames_q <= frames_d;
      ovr_q    <= ovr_d;
`ifdef FRAME_CTRL_TIMEOUT_EN
      to_q     <= to_d;
      tocnt_q  <= tocnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cfo_d    = cfo_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hold_d   = '0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    frames_d = frames_q;
    ovr_d    = ovr_q;
`ifdef FRAME_CTRL_TIMEOUT_EN
    to_d     = '0;
    tocnt_d  = tocnt_q;
`endif

    // Strobes while disabled are neither captured nor counted as overruns.
    if (enable_i && det_strobe_i && (state_q != ST_ARMED) && (ovr_q != '1)) begin
      ovr_d = ovr_q + 16'd1;
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (det_strobe_i) begin
            state_d = ST_CAPTURE;
            cfo_d   = det_cfo_i;
            len_d   = (frame_len_i == '0) ? LEN_WIDTH'(1) : frame_len_i;
            cnt_d   = '0;
            start_d = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == {1'b0, len_q}) begin
              state_d  = ST_WAIT_ACK;
              done_d   = 1'b1;
              frames_d = frames_q + 32'd1;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (cpu_ack_i) begin
            state_d = POST_ACK;
`ifdef FRAME_CTRL_TIMEOUT_EN
          end else if (to_q == TO_LAST) begin
            state_d = POST_ACK;
            if (tocnt_q != '1) tocnt_d = tocnt_q + 16'd1;
          end else begin
            to_d = to_q + 1'b1;
`endif
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_q;
          if (sample_valid_i) begin
            if (hold_q == HOLD_LAST) state_d = ST_ARMED;
            else                     hold_d  = hold_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign capture_en_o    = (state_q == ST_CAPTURE);
  assign irq_o           = (state_q == ST_WAIT_ACK);
  assign capture_start_o = start_q;
  assign capture_done_o  = done_q;
  assign cfo_o           = cfo_q;
  assign state_o         = state_q;
  assign frame_count_o   = frames_q;
  assign overrun_count_o = ovr_q;
`ifdef FRAME_CTRL_TIMEOUT_EN
  assign timeout_count_o = tocnt_q;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: directed scenarios plus random traffic
// compared every cycle against a countdown-based behavioural model.
module tb_frame_capture_ctrl;
  localparam int unsigned HOLD = 64;
`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`endif

  logic        clk = 1'b0;
  logic        rst, en, sv, st, ack;
  logic [15:0] cfo_in, len_in;
  logic        capture_en_o, capture_start_o, capture_done_o, irq_o;
  logic [15:0] cfo_o, overrun_count_o;
  logic [2:0]  state_o;
  logic [31:0] frame_count_o;
`ifdef FRAME_CTRL_TIMEOUT_EN
  logic [15:0] timeout_count_o;
`endif

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .CFO_WIDTH(16),
    .LEN_WIDTH(16),
    .HOLDOFF(HOLD)
`ifdef FRAME_CTRL_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(en),
    .sample_valid_i(sv),
    .det_strobe_i(st),
    .det_cfo_i(cfo_in),
    .frame_len_i(len_in),
    .cpu_ack_i(ack),
    .capture_en_o(capture_en_o),
    .capture_start_o(capture_start_o),
    .capture_done_o(capture_done_o),
    .irq_o(irq_o),
    .cfo_o(cfo_o),
    .state_o(state_o),
    .frame_count_o(frame_count_o),
`ifdef FRAME_CTRL_TIMEOUT_EN
    .timeout_count_o(timeout_count_o),
`endif
    .overrun_count_o(overrun_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase number plus remaining-sample / remaining-holdoff countdowns.
  int          m_state, m_left, m_hold, m_wait;
  int unsigned m_frames, m_ovr, m_tmo;
  logic [15:0] m_cfo;
  bit          m_start, m_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic leave_wait();
    if (HOLD == 0) m_state = 1;
    else begin
      m_state = 4;
      m_hold  = HOLD;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_state = 0; m_left = 0; m_hold = 0; m_wait = 0;
      m_frames = 0; m_ovr = 0; m_tmo = 0; m_cfo = '0;
      m_start = 0; m_done = 0;
    end else begin
      m_start = 0;
      m_done  = 0;
      if (st && en && m_state != 1 && m_ovr < 65535) m_ovr++;
      if (!en) m_state = 0;
      else begin
        case (m_state)
          0: m_state = 1;
          1: if (st) begin
               m_state = 2;
               m_cfo   = cfo_in;
               m_left  = (len_in == 0) ? 1 : int'(len_in);
               m_start = 1;
             end
          2: if (sv) begin
               m_left--;
               if (m_left == 0) begin
                 m_state = 3;
                 m_done  = 1;
                 m_frames++;
                 m_wait  = 1;
               end
             end
          3: begin
               if (ack) leave_wait();
`ifdef FRAME_CTRL_TIMEOUT_EN
               else if (m_wait == TMO) begin
                 leave_wait();
                 if (m_tmo < 65535) m_tmo++;
               end else m_wait++;
`endif
             end
          4: if (sv) begin
               m_hold--;
               if (m_hold == 0) m_state = 1;
             end
          default: m_state = 0;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state_o), 32'(m_state));
    check("capture_en", 32'(capture_en_o), 32'(m_state == 2));
    check("irq", 32'(irq_o), 32'(m_state == 3));
    check("start", 32'(capture_start_o), 32'(m_start));
    check("done", 32'(capture_done_o), 32'(m_done));
    check("cfo", 32'(cfo_o), 32'(m_cfo));
    check("frames", frame_count_o, m_frames);
    check("overrun", 32'(overrun_count_o), m_ovr);
`ifdef FRAME_CTRL_TIMEOUT_EN
    check("timeouts", 32'(timeout_count_o), m_tmo);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n_en, n_start, n_done, gated;
    int unsigned ovr_exp, fr0;
`ifdef FRAME_CTRL_TIMEOUT_EN
    int unsigned tmo0;
`endif
    rst = 1; en = 0; sv = 0; st = 0; ack = 0; cfo_in = '0; len_in = '0;
    tick(); tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_frames", frame_count_o, 32'd0);
    check("rst_overrun", 32'(overrun_count_o), 32'd0);

    // Basic capture, len 8 with continuous samples
    rst = 0; en = 1; sv = 1;
    tick();
    check("armed", 32'(state_o), 32'd1);
    st = 1; cfo_in = 16'h1234; len_in = 16'd8;
    tick();
    st = 0;
    n_en = 0; n_start = 0; n_done = 0;
    repeat (12) begin
      n_en    += int'(capture_en_o);
      n_start += int'(capture_start_o);
      n_done  += int'(capture_done_o);
      tick();
    end
    check("t1_en_cycles", 32'(n_en), 32'd8);
    check("t1_start_pulses", 32'(n_start), 32'd1);
    check("t1_done_pulses", 32'(n_done), 32'd1);
    check("t1_irq", 32'(irq_o), 32'd1);
    check("t1_cfo", 32'(cfo_o), 32'h1234);
    check("t1_frames", frame_count_o, 32'd1);

    // Ack, holdoff boundary at exactly HOLD valid samples
    ack = 1; tick(); ack = 0;
    check("t2_holdoff", 32'(state_o), 32'd4);
    repeat (HOLD - 1) tick();
    check("t2_holdoff_last", 32'(state_o), 32'd4);
    tick();
    check("t2_rearm", 32'(state_o), 32'd1);

    // Sparse samples, len 4
    st = 1; cfo_in = 16'h0002; len_in = 16'd4; sv = 0;
    tick();
    st = 0; gated = 0;
    for (int i = 0; i < 20; i++) begin
      sv = (i % 3 == 0);
      if (capture_en_o && sv) gated++;
      tick();
    end
    check("t2_gated", 32'(gated), 32'd4);
    check("t2_wait", 32'(state_o), 32'd3);

    // Overruns during CAPTURE, WAIT_ACK, HOLDOFF
    ack = 1; tick(); ack = 0; sv = 1;
    repeat (HOLD) tick();
    ovr_exp = m_ovr + 3;
    st = 1; cfo_in = 16'hABCD; len_in = 16'd8;
    tick(); st = 0;
    tick(); tick();
    st = 1; cfo_in = 16'h5555; tick(); st = 0;
    repeat (8) tick();
    st = 1; tick(); st = 0;
    ack = 1; tick(); ack = 0;
    tick();
    st = 1; tick(); st = 0;
    check("t3_overrun", 32'(overrun_count_o), ovr_exp);
    check("t3_cfo_hold", 32'(cfo_o), 32'hABCD);
    repeat (HOLD) tick();
    st = 1; cfo_in = 16'h0BEE; len_in = 16'd2;
    tick(); st = 0;
    check("t3_recapture", 32'(state_o), 32'd2);
    check("t3_new_cfo", 32'(cfo_o), 32'h0BEE);
    repeat (3) tick();
    ack = 1; tick(); ack = 0;
    repeat (HOLD) tick();

    // Disable at count 5 of 8
    fr0 = m_frames;
    st = 1; cfo_in = 16'h0044; len_in = 16'd8;
    tick(); st = 0;
    repeat (5) tick();
    en = 0; tick();
    check("t4_idle", 32'(state_o), 32'd0);
    check("t4_en_low", 32'(capture_en_o), 32'd0);
    check("t4_no_done", 32'(capture_done_o), 32'd0);
    check("t4_frames", frame_count_o, fr0);
    en = 1; tick();
    check("t4_rearm", 32'(state_o), 32'd1);

    // len 0 -> single sample, then saturate overruns
    st = 1; len_in = 16'd0; cfo_in = 16'h0777;
    tick(); st = 0;
    check("t5_cap", 32'(capture_en_o), 32'd1);
    tick();
    check("t5_wait", 32'(state_o), 32'd3);
    check("t5_done", 32'(capture_done_o), 32'd1);
    st = 1;
    repeat (70000) tick();
    st = 0;
    check("t5_saturate", 32'(overrun_count_o), 32'h0000FFFF);
    ack = 1; tick(); ack = 0;
    repeat (HOLD) tick();

`ifdef FRAME_CTRL_TIMEOUT_EN
    tmo0 = m_tmo;
    st = 1; len_in = 16'd1; tick(); st = 0;
    tick();
    repeat (TMO - 1) tick();
    check("t6_irq_last", 32'(irq_o), 32'd1);
    tick();
    check("t6_irq_drop", 32'(irq_o), 32'd0);
    check("t6_tmo_count", 32'(timeout_count_o), tmo0 + 1);
    repeat (HOLD) tick();
    st = 1; tick(); st = 0;
    tick();
    repeat (TMO - 2) tick();
    ack = 1; tick(); ack = 0;
    check("t6_ack_99", 32'(state_o), 32'd4);
    check("t6_no_tmo", 32'(timeout_count_o), tmo0 + 1);
`endif

    // Random traffic
    repeat (3000) begin
      rst    = ($urandom_range(499) == 0);
      en     = ($urandom_range(19) != 0);
      sv     = 1'($urandom_range(1));
      st     = ($urandom_range(9) == 0);
      ack    = ($urandom_range(7) == 0);
      cfo_in = 16'($urandom);
      len_in = 16'($urandom_range(6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
